// File: rtl/instruction_issue_fifo_pkg.sv
// ============================================================================
// Module      : instruction_issue_fifo_pkg
// Description : Shared opcodes, widths, reset word and issue-FSM state type.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package instruction_issue_fifo_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int VRF_AWIDTH   = 10;
    localparam int INSTR_WIDTH  = OPCODE_WIDTH + 2 * VRF_AWIDTH;

    localparam logic [OPCODE_WIDTH-1:0] V_RD      = 4'd0;
    localparam logic [OPCODE_WIDTH-1:0] V_WR      = 4'd1;
    localparam logic [OPCODE_WIDTH-1:0] M_RD      = 4'd2;
    localparam logic [OPCODE_WIDTH-1:0] M_WR      = 4'd3;
    localparam logic [OPCODE_WIDTH-1:0] MV_MUL    = 4'd4;
    localparam logic [OPCODE_WIDTH-1:0] VV_ADD    = 4'd5;
    localparam logic [OPCODE_WIDTH-1:0] VV_SUB    = 4'd6;
    localparam logic [OPCODE_WIDTH-1:0] VV_PASS   = 4'd7;
    localparam logic [OPCODE_WIDTH-1:0] VV_MUL    = 4'd8;
    localparam logic [OPCODE_WIDTH-1:0] V_RELU    = 4'd9;
    localparam logic [OPCODE_WIDTH-1:0] V_SIGM    = 4'd10;
    localparam logic [OPCODE_WIDTH-1:0] V_TANH    = 4'd11;
    localparam logic [OPCODE_WIDTH-1:0] END_CHAIN = 4'd12;

    // Word presented while idle after reset/flush: keeps the decoder in its reset-chain state.
    localparam logic [INSTR_WIDTH-1:0] c_RESET_WORD = {END_CHAIN, {(2 * VRF_AWIDTH){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } issue_state_t;

    function automatic logic is_long_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == MV_MUL) || (op == V_RELU) || (op == V_SIGM) || (op == V_TANH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_issue_fifo_instr_sync_fifo.sv
// ============================================================================
// Module      : instr_sync_fifo
// Description : Single-clock FIFO with occupancy count, combinational head read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instr_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_fire;
    logic             w_pop_fire;

    assign o_full      = (r_count == c_FULL_COUNT);
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign o_head      = r_mem[r_rd_ptr];
    // Full blocks a push even when a pop lands in the same cycle: no bypass.
    assign w_push_fire = i_push && !o_full;
    assign w_pop_fire  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_issue_fifo.sv
// ============================================================================
// Module      : instruction_issue_fifo
// Description : Packs host instructions into a FIFO and issues them to the
//               decoder, holding long ops until op_done. Optional macro
//               ISSUE_OPCODE_CHECK_EN discards opcodes 13..15.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instruction_issue_fifo
    import instruction_issue_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [OPCODE_WIDTH-1:0]       push_opcode,
    input  logic [VRF_AWIDTH-1:0]         push_op1,
    input  logic [VRF_AWIDTH-1:0]         push_op2,
    input  logic                          run_en,
    input  logic                          op_done,
    input  logic                          flush,
    output logic [INSTR_WIDTH-1:0]        instruction,
    output logic                          instr_valid,
    output logic                          busy,
    output logic                          chain_done,
`ifdef ISSUE_OPCODE_CHECK_EN
    output logic                          illegal_opcode,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] c_ONE = (AW + 1)'(1);

    issue_state_t            r_state;
    issue_state_t            w_state_nxt;
    issue_state_t            w_short_nxt;
    logic [INSTR_WIDTH-1:0]  r_instruction;
    logic                    r_instr_valid;
    logic                    r_chain_done;
    logic [INSTR_WIDTH-1:0]  w_head;
    logic [OPCODE_WIDTH-1:0] w_head_op;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push_fire;
    logic                    w_more;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_valid_nxt;
    logic                    w_chain_nxt;
`ifdef ISSUE_OPCODE_CHECK_EN
    logic                    r_illegal;
    logic                    w_illegal;
    logic                    w_illegal_nxt;
`endif

    instr_sync_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (resetn),
        .i_flush     (flush),
        .i_push      (push_valid),
        .i_push_data ({push_opcode, push_op1, push_op2}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

    assign push_ready  = !w_full;
    assign w_push_fire = push_valid && push_ready;
    assign w_head_op   = w_head[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    // Occupancy after this cycle's pop, counting a push landing in the same cycle.
    assign w_more      = (fifo_count > c_ONE) || w_push_fire;
    assign w_short_nxt = (run_en && w_more) ? ISSUE : IDLE;

    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign chain_done  = r_chain_done;
    assign busy        = (r_state != IDLE) || !w_empty;
`ifdef ISSUE_OPCODE_CHECK_EN
    assign illegal_opcode = r_illegal;
    assign w_illegal      = (w_head_op > END_CHAIN);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_valid_nxt = 1'b0;
        w_chain_nxt = 1'b0;
`ifdef ISSUE_OPCODE_CHECK_EN
        w_illegal_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (run_en && !w_empty) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_empty) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_pop = 1'b1;
`ifdef ISSUE_OPCODE_CHECK_EN
                    if (w_illegal) begin
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = w_short_nxt;
                    end else
`endif
                    if (is_long_op(w_head_op)) begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = WAIT_DONE;
                    end else if (w_head_op == END_CHAIN) begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_chain_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = w_short_nxt;
                    end
                end
            end
            WAIT_DONE: begin
                if (op_done) begin
                    w_state_nxt = (run_en && !w_empty) ? ISSUE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_instruction <= c_RESET_WORD;
            r_instr_valid <= 1'b0;
            r_chain_done  <= 1'b0;
`ifdef ISSUE_OPCODE_CHECK_EN
            r_illegal     <= 1'b0;
`endif
        end else if (flush) begin
            r_state       <= IDLE;
            r_instruction <= c_RESET_WORD;
            r_instr_valid <= 1'b0;
            r_chain_done  <= 1'b0;
`ifdef ISSUE_OPCODE_CHECK_EN
            r_illegal     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            if (w_load) begin
                r_instruction <= w_head;
            end
            r_instr_valid <= w_valid_nxt;
            r_chain_done  <= w_chain_nxt;
`ifdef ISSUE_OPCODE_CHECK_EN
            r_illegal     <= w_illegal_nxt;
`endif
        end
    end

endmodule

`default_nettype wire
